// File: rtl/a2rt_frame_sink.sv
// a2rt_frame_sink: AXI4-Stream pixel sink with raster tracking and tlast checks.
// Per-frame signature is present only when A2RT_SINK_CHECKSUM_EN is defined.
module a2rt_frame_sink #(
    parameter int         DATA_WIDTH    = 24,
    parameter int         SCREEN_WIDTH  = 800,
    parameter int         SCREEN_HEIGHT = 600,
    parameter logic [7:0] READY_PATTERN = 8'hFF,
    localparam int        XW = (SCREEN_WIDTH > 1) ? $clog2(SCREEN_WIDTH) : 1,
    localparam int        YW = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  pix_valid_o,
    output logic [XW-1:0]         pix_x_o,
    output logic [YW-1:0]         pix_y_o,
    output logic [DATA_WIDTH-1:0] pix_data_o,
    output logic                  frame_done_o,
    output logic [15:0]           frame_count_o,
    output logic [31:0]           checksum_o,
    output logic                  err_early_last_o,
    output logic                  err_missing_last_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                  state_q;
    logic [7:0]              mask_q;
    logic [7:0]              mask_d;
    logic                    tready_q;
    logic [XW-1:0]           x_q;
    logic [YW-1:0]           y_q;
    logic                    pix_valid_q;
    logic [XW-1:0]           pix_x_q;
    logic [YW-1:0]           pix_y_q;
    logic [DATA_WIDTH-1:0]   pix_data_q;
    logic                    frame_done_q;
    logic [15:0]             frame_count_q;
    logic                    err_early_q;
    logic                    err_missing_q;

    logic beat;
    logic x_end;
    logic y_end;
    logic term;

    // tready_q is only ever set while in RECV
    assign beat   = tready_q & s_axis_tvalid;
    assign x_end  = (x_q == XW'(SCREEN_WIDTH - 1));
    assign y_end  = (y_q == YW'(SCREEN_HEIGHT - 1));
    assign term   = beat & (s_axis_tlast | (x_end & y_end));
    assign mask_d = {mask_q[0], mask_q[7:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            mask_q        <= '0;
            tready_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_data_q    <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            err_early_q   <= 1'b0;
            err_missing_q <= 1'b0;
        end else begin
            pix_valid_q  <= beat;
            frame_done_q <= 1'b0;
            if (beat) begin
                pix_x_q    <= x_q;
                pix_y_q    <= y_q;
                pix_data_q <= s_axis_tdata;
            end
            unique case (state_q)
                IDLE: begin
                    if (enable_i) begin
                        state_q  <= RECV;
                        mask_q   <= READY_PATTERN;
                        tready_q <= READY_PATTERN[0];
                    end
                end
                RECV: begin
                    mask_q <= mask_d;
                    if (term) begin
                        state_q       <= DONE;
                        tready_q      <= 1'b0;
                        x_q           <= '0;
                        y_q           <= '0;
                        frame_done_q  <= 1'b0 | 1'b1;
                        frame_count_q <= frame_count_q + 16'd1;
                        if (s_axis_tlast && !(x_end && y_end)) begin
                            err_early_q <= 1'b1;
                        end
                        if (!s_axis_tlast) begin
                            err_missing_q <= 1'b1;
                        end
                    end else begin
                        tready_q <= mask_d[0];
                        if (beat) begin
                            if (x_end) begin
                                x_q <= '0;
                                y_q <= y_q + YW'(1);
                            end else begin
                                x_q <= x_q + XW'(1);
                            end
                        end
                    end
                end
                DONE: begin
                    if (enable_i) begin
                        state_q  <= RECV;
                        mask_q   <= READY_PATTERN;
                        tready_q <= READY_PATTERN[0];
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    tready_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef A2RT_SINK_CHECKSUM_EN
    logic [31:0] sig_q;
    logic [31:0] sig_d;
    logic [31:0] checksum_q;

    assign sig_d = {sig_q[30:0], sig_q[31]} ^ 32'(s_axis_tdata);

    // Cleared on the terminating beat so the next frame starts from zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q      <= '0;
            checksum_q <= '0;
        end else if (term) begin
            sig_q      <= '0;
            checksum_q <= sig_d;
        end else if (beat) begin
            sig_q <= sig_d;
        end
    end

    assign checksum_o = checksum_q;
`else
    assign checksum_o = '0;
`endif

    assign s_axis_tready      = tready_q;
    assign pix_valid_o        = pix_valid_q;
    assign pix_x_o            = pix_x_q;
    assign pix_y_o            = pix_y_q;
    assign pix_data_o         = pix_data_q;
    assign frame_done_o       = frame_done_q;
    assign frame_count_o      = frame_count_q;
    assign err_early_last_o   = err_early_q;
    assign err_missing_last_o = err_missing_q;

endmodule

// File: tb/tb_a2rt_frame_sink.sv
// Bench for a2rt_frame_sink: two instances (full and 50% ready pattern)
// driven from beat queues and checked against a beat-level reference model.
module tb_a2rt_frame_sink;

    localparam int W = 4;
    localparam int H = 2;
    localparam int NPIX = W * H;
`ifdef A2RT_SINK_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    typedef struct packed {
        logic [23:0] d;
        logic        l;
    } beat_t;

    logic clk;
    logic rst;
    logic en;
    logic [1:0]        vld;
    logic [1:0][23:0]  dat;
    logic [1:0]        lst;
    logic [1:0]        rdy_w;
    logic [1:0]        pv_w;
    logic [1:0][1:0]   px_w;
    logic [1:0]        py_w;
    logic [1:0][23:0]  pd_w;
    logic [1:0]        done_w;
    logic [1:0][15:0]  cnt_w;
    logic [1:0][31:0]  ck_w;
    logic [1:0]        ee_w;
    logic [1:0]        em_w;

    int n_tests = 0;
    int n_fail  = 0;
    bit gaps    = 0;

    beat_t q0[$];
    beat_t q1[$];

    // reference model: per-instance frame progress counted in beats
    int          m_st[2];
    int          m_k[2];
    int          m_n[2];
    logic [31:0] m_sig[2];
    logic        e_rdy[2];
    logic        e_pv[2];
    int          e_px[2];
    int          e_py[2];
    logic [23:0] e_pd[2];
    logic        e_done[2];
    logic [15:0] e_cnt[2];
    logic [31:0] e_ck[2];
    logic        e_ee[2];
    logic        e_em[2];

    a2rt_frame_sink #(
        .DATA_WIDTH(24), .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H),
        .READY_PATTERN(8'hFF)
    ) u0 (
        .clk(clk), .rst(rst), .enable_i(en),
        .s_axis_tvalid(vld[0]), .s_axis_tready(rdy_w[0]),
        .s_axis_tdata(dat[0]), .s_axis_tlast(lst[0]),
        .pix_valid_o(pv_w[0]), .pix_x_o(px_w[0]), .pix_y_o(py_w[0]),
        .pix_data_o(pd_w[0]), .frame_done_o(done_w[0]),
        .frame_count_o(cnt_w[0]), .checksum_o(ck_w[0]),
        .err_early_last_o(ee_w[0]), .err_missing_last_o(em_w[0])
    );

    a2rt_frame_sink #(
        .DATA_WIDTH(24), .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H),
        .READY_PATTERN(8'b0101_0101)
    ) u1 (
        .clk(clk), .rst(rst), .enable_i(en),
        .s_axis_tvalid(vld[1]), .s_axis_tready(rdy_w[1]),
        .s_axis_tdata(dat[1]), .s_axis_tlast(lst[1]),
        .pix_valid_o(pv_w[1]), .pix_x_o(px_w[1]), .pix_y_o(py_w[1]),
        .pix_data_o(pd_w[1]), .frame_done_o(done_w[1]),
        .frame_count_o(cnt_w[1]), .checksum_o(ck_w[1]),
        .err_early_last_o(ee_w[1]), .err_missing_last_o(em_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] pat_of(input int i);
        return (i == 0) ? 8'hFF : 8'h55;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_enter(input int i);
        logic [7:0] p;
        p = pat_of(i);
        m_st[i]  = 1;
        m_k[i]   = 0;
        e_rdy[i] = p[0];
    endtask

    task automatic model_edge(input int i, input logic v,
                              input logic [23:0] d, input logic l,
                              output logic beat);
        logic [7:0] p;
        beat = 1'b0;
        p = pat_of(i);
        if (rst) begin
            m_st[i] = 0; m_k[i] = 0; m_n[i] = 0; m_sig[i] = '0;
            e_rdy[i] = 0; e_pv[i] = 0; e_px[i] = 0; e_py[i] = 0;
            e_pd[i] = '0; e_done[i] = 0; e_cnt[i] = '0; e_ck[i] = '0;
            e_ee[i] = 0; e_em[i] = 0;
        end else begin
            e_done[i] = 1'b0;
            e_pv[i]   = 1'b0;
            if (m_st[i] == 0) begin
                if (en) model_enter(i);
            end else if (m_st[i] == 1) begin
                beat    = e_rdy[i] & v;
                e_pv[i] = beat;
                m_k[i]++;
                e_rdy[i] = p[m_k[i] % 8];
                if (beat) begin
                    e_px[i]  = m_n[i] % W;
                    e_py[i]  = m_n[i] / W;
                    e_pd[i]  = d;
                    m_sig[i] = ((m_sig[i] << 1) | (m_sig[i] >> 31))
                               ^ {8'h00, d};
                    if (l || m_n[i] == NPIX - 1) begin
                        if (l && m_n[i] != NPIX - 1) e_ee[i] = 1'b1;
                        if (!l) e_em[i] = 1'b1;
                        e_cnt[i]  = e_cnt[i] + 16'd1;
                        e_ck[i]   = CK_EN ? m_sig[i] : 32'h0;
                        m_sig[i]  = '0;
                        m_n[i]    = 0;
                        m_st[i]   = 2;
                        e_done[i] = 1'b1;
                        e_rdy[i]  = 1'b0;
                    end else begin
                        m_n[i]++;
                    end
                end
            end else begin
                if (en) model_enter(i);
                else m_st[i] = 0;
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d.tready", i), 32'(rdy_w[i]), 32'(e_rdy[i]));
            chk($sformatf("u%0d.pix_valid", i), 32'(pv_w[i]), 32'(e_pv[i]));
            chk($sformatf("u%0d.pix_x", i), 32'(px_w[i]), 32'(e_px[i]));
            chk($sformatf("u%0d.pix_y", i), 32'(py_w[i]), 32'(e_py[i]));
            chk($sformatf("u%0d.pix_data", i), 32'(pd_w[i]), 32'(e_pd[i]));
            chk($sformatf("u%0d.frame_done", i), 32'(done_w[i]),
                32'(e_done[i]));
            chk($sformatf("u%0d.frame_count", i), 32'(cnt_w[i]),
                32'(e_cnt[i]));
            chk($sformatf("u%0d.checksum", i), ck_w[i], e_ck[i]);
            chk($sformatf("u%0d.err_early", i), 32'(ee_w[i]), 32'(e_ee[i]));
            chk($sformatf("u%0d.err_missing", i), 32'(em_w[i]),
                32'(e_em[i]));
        end
    endtask

    task automatic step();
        beat_t h;
        logic  b;
        for (int i = 0; i < 2; i++) begin
            if ((i == 0 && q0.size() != 0) || (i == 1 && q1.size() != 0)) begin
                h = (i == 0) ? q0[0] : q1[0];
                vld[i] = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                dat[i] = h.d;
                lst[i] = h.l;
            end else begin
                vld[i] = 1'b0;
                dat[i] = 24'($urandom);
                lst[i] = 1'($urandom);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            model_edge(i, vld[i], dat[i], lst[i], b);
            if (b && i == 0) void'(q0.pop_front());
            if (b && i == 1) void'(q1.pop_front());
        end
        compare_all();
    endtask

    task automatic push(input int n, input int base, input int last_at);
        beat_t bt;
        for (int j = 0; j < n; j++) begin
            bt.d = 24'(base + j);
            bt.l = (j == last_at);
            q0.push_back(bt);
            q1.push_back(bt);
        end
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while ((q0.size() != 0 || q1.size() != 0) && c < budget) begin
            step();
            c++;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout observed=%0d/%0d beats left expected=0",
                     q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
        step();
    endtask

    task automatic chk_frame(input string tag, input int cnt,
                             input logic [31:0] ck, input logic ee,
                             input logic em);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s.u%0d.count", tag, i), 32'(cnt_w[i]), 32'(cnt));
            chk($sformatf("%s.u%0d.cksum", tag, i), ck_w[i],
                CK_EN ? ck : 32'h0);
            chk($sformatf("%s.u%0d.early", tag, i), 32'(ee_w[i]), 32'(ee));
            chk($sformatf("%s.u%0d.missing", tag, i), 32'(em_w[i]), 32'(em));
        end
    endtask

    initial begin
        beat_t bt;
        rst = 1'b1;
        en  = 1'b0;
        vld = '0;
        dat = '0;
        lst = '0;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b0;
        step();
        en = 1'b1;
        step();
        chk("rel.u0.tready", 32'(rdy_w[0]), 32'd1);
        chk("rel.u1.tready", 32'(rdy_w[1]), 32'd1);

        push(NPIX, 1, NPIX - 1);
        drain(100);
        chk_frame("nominal", 1, 32'h16, 1'b0, 1'b0);

        push(3, 1, 2);
        drain(100);
        chk_frame("early", 2, 32'h3, 1'b1, 1'b0);

        push(NPIX, 1, NPIX - 1);
        drain(100);
        chk_frame("after_early", 3, 32'h16, 1'b1, 1'b0);

        push(NPIX, 1, -1);
        push(NPIX, 1, NPIX - 1);
        drain(100);
        chk_frame("missing", 5, 32'h16, 1'b1, 1'b1);

        gaps = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int j = 0; j < 24; j++) begin
                bt.d = 24'($urandom);
                bt.l = ((j % NPIX) == NPIX - 1) ? ($urandom_range(0, 4) != 0)
                                                : ($urandom_range(0, 15) == 0);
                q0.push_back(bt);
                q1.push_back(bt);
            end
            for (int c = 0; c < 600 && (q0.size() != 0 || q1.size() != 0);
                 c++) begin
                en = ($urandom_range(0, 7) != 0);
                step();
            end
            en = 1'b1;
            drain(200);
        end
        gaps = 1'b0;

        push(5, 1, -1);
        drain(100);
        rst = 1'b1;
        step();
        chk_frame("reset", 0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        push(NPIX, 1, NPIX - 1);
        drain(100);
        chk_frame("post_reset", 1, 32'h16, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
